// File: rtl/kmac_app_sched.sv
// kmac_app_sched
//   Arbitrates the shared KMAC/SHA3 engine among NumReq hardware requesters.
//   A round-robin winner is granted, the core is started, the winner's message
//   beats are forwarded to the core FIFO, the core is told to process, and the
//   grant is held until the winner acknowledges its digest.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_i               per-requester operation request (level)
//   gnt_o               one-hot grant, held from arbitration to digest ack
//   req_valid_i/data_i/strb_i/last_i, req_ready_o
//                       per-requester message stream (data/strb flattened,
//                       requester i occupies slice i)
//   req_done_o, req_ack_i
//                       digest available / digest consumed
//   fifo_valid_o/data_o/strb_o, fifo_ready_i
//                       stream into the core message FIFO
//   core_start_o, core_process_o, core_absorbed_i, core_done_o
//                       core sequencing
//   busy_o              an operation is in progress
//   error_o             sticky fatal error (stream timeout or corrupted state)
module kmac_app_sched #(
  parameter int NumReq        = 3,
  parameter int MsgWidth      = 64,
  parameter int MsgStrbW      = 8,
  parameter int TimeoutCycles = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_i,
  output logic [NumReq-1:0]            gnt_o,
  input  logic [NumReq-1:0]            req_valid_i,
  input  logic [NumReq*MsgWidth-1:0]   req_data_i,
  input  logic [NumReq*MsgStrbW-1:0]   req_strb_i,
  input  logic [NumReq-1:0]            req_last_i,
  output logic [NumReq-1:0]            req_ready_o,
  output logic [NumReq-1:0]            req_done_o,
  input  logic [NumReq-1:0]            req_ack_i,
  output logic                         fifo_valid_o,
  output logic [MsgWidth-1:0]          fifo_data_o,
  output logic [MsgStrbW-1:0]          fifo_strb_o,
  input  logic                         fifo_ready_i,
  output logic                         core_start_o,
  output logic                         core_process_o,
  input  logic                         core_absorbed_i,
  output logic                         core_done_o,
  output logic                         busy_o,
  output logic                         error_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(TimeoutCycles + 1);

  // Codes are pairwise at Hamming distance >= 3, so a single upset can never
  // turn one legal state into another; any illegal code falls into StError.
  typedef enum logic [5:0] {
    StIdle    = 6'b000000,
    StStart   = 6'b100011,
    StMsg     = 6'b010101,
    StProcess = 6'b001110,
    StWait    = 6'b110110,
    StDigest  = 6'b101101,
    StError   = 6'b011011
  } state_e;

  state_e              state, state_next;
  logic [IdxW-1:0]     ptr, ptr_next;
  logic [IdxW-1:0]     gidx, gidx_next;
  logic [CntW-1:0]     tcnt, tcnt_next;
  logic [IdxW-1:0]     cand, arb_idx;
  logic                arb_found;
  logic [NumReq-1:0]   gnt_vec;
  logic                granted, in_msg, handshake;
  logic                gvalid, glast, gack;
  logic [MsgWidth-1:0] gdata;
  logic [MsgStrbW-1:0] gstrb;

  // Round-robin search starts just above the last winner and wraps.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NumReq; i++) begin
      cand = IdxW'((int'(ptr) + i) % NumReq);
      if (!arb_found && req_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Grantee's stream and acknowledge.
  always_comb begin
    gvalid = 1'b0;
    glast  = 1'b0;
    gack   = 1'b0;
    gdata  = '0;
    gstrb  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gidx == IdxW'(i)) begin
        gvalid = req_valid_i[i];
        glast  = req_last_i[i];
        gack   = req_ack_i[i];
        gdata  = req_data_i[i*MsgWidth +: MsgWidth];
        gstrb  = req_strb_i[i*MsgStrbW +: MsgStrbW];
      end
    end
  end

  assign gnt_vec   = NumReq'(1) << gidx;
  assign granted   = state inside {StStart, StMsg, StProcess, StWait, StDigest};
  assign in_msg    = (state == StMsg);
  assign handshake = in_msg & gvalid & fifo_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= StIdle;
      ptr   <= IdxW'(NumReq - 1);
      gidx  <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      gidx  <= gidx_next;
      tcnt  <= tcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    gidx_next  = gidx;
    tcnt_next  = '0;
    case (state)
      StIdle: begin
        if (arb_found) begin
          gidx_next  = arb_idx;
          ptr_next   = arb_idx;
          state_next = StStart;
        end
      end
      StStart: state_next = StMsg;
      StMsg: begin
        if (handshake) begin
          if (glast) state_next = StProcess;
        end else if (tcnt == CntW'(TimeoutCycles - 1)) begin
          // This stall cycle is the TimeoutCycles-th in a row.
          state_next = StError;
        end else begin
          tcnt_next = tcnt + CntW'(1);
        end
      end
      StProcess: state_next = StWait;
      StWait: begin
        if (core_absorbed_i) state_next = StDigest;
      end
      StDigest: begin
        if (gack) state_next = StIdle;
      end
      StError: state_next = StError;
      default: state_next = StError;
    endcase
  end

  // Outputs decode from the state register so reset clears them at once.
  assign gnt_o          = granted ? gnt_vec : '0;
  assign req_ready_o    = in_msg ? (gnt_vec & {NumReq{fifo_ready_i}}) : '0;
  assign fifo_valid_o   = in_msg & gvalid;
  assign fifo_data_o    = in_msg ? gdata : '0;
  assign fifo_strb_o    = in_msg ? gstrb : '0;
  assign req_done_o     = (state == StDigest) ? gnt_vec : '0;
  assign core_done_o    = (state == StDigest) & gack;
  assign core_start_o   = (state == StStart);
  assign core_process_o = (state == StProcess);
  assign busy_o         = granted;
  assign error_o        = (state == StError);

endmodule

// File: tb/tb_kmac_app_sched.sv
// Bench for kmac_app_sched: directed stimulus, a phase-level reference model
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_kmac_app_sched;
  localparam int N  = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    req = '0, vld = '0, last = '0, ack = '0;
  logic [63:0]   dat [3];
  logic [7:0]    stb [3];
  logic [191:0]  req_data;
  logic [23:0]   req_strb;
  logic          fifo_ready = 1'b1, absorbed = 1'b0;

  logic [2:0]  gnt_o, req_ready_o, req_done_o;
  logic        fifo_valid_o, core_start_o, core_process_o, core_done_o;
  logic        busy_o, error_o;
  logic [63:0] fifo_data_o;
  logic [7:0]  fifo_strb_o;

  assign req_data = {dat[2], dat[1], dat[0]};
  assign req_strb = {stb[2], stb[1], stb[0]};

  kmac_app_sched #(.NumReq(N), .MsgWidth(64), .MsgStrbW(8), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_o),
    .req_valid_i(vld), .req_data_i(req_data), .req_strb_i(req_strb),
    .req_last_i(last), .req_ready_o(req_ready_o), .req_done_o(req_done_o),
    .req_ack_i(ack), .fifo_valid_o(fifo_valid_o), .fifo_data_o(fifo_data_o),
    .fifo_strb_o(fifo_strb_o), .fifo_ready_i(fifo_ready),
    .core_start_o(core_start_o), .core_process_o(core_process_o),
    .core_absorbed_i(absorbed), .core_done_o(core_done_o),
    .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [63:0] d; logic [7:0] s; } beat_t;
  beat_t      exp_q [$];
  int         ph = 0;          // 0 idle 1 start 2 msg 3 process 4 wait 5 digest 6 error
  logic [1:0] g_m = '0;
  logic [1:0] ptr_m = 2'd2;
  int         tcnt_m = 0;
  int         beats_seen = 0;

  function automatic int rr(input logic [1:0] p, input logic [2:0] r);
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (int'(p) + i) % N;
      if (((r >> c) & 3'd1) != 3'd0) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [2:0] eg;
    logic       ev;
    int         nxt;
    beat_t      b;
    if (rst) begin
      chk("rst_ctrl", 64'({gnt_o, req_ready_o, req_done_o, fifo_valid_o, core_start_o,
                            core_process_o, core_done_o, busy_o, error_o}), 64'd0);
      chk("rst_data", 64'(fifo_data_o) | 64'(fifo_strb_o), 64'd0);
      ph = 0; ptr_m = 2'd2; tcnt_m = 0; g_m = '0;
      exp_q.delete();
    end else begin
      eg = (ph >= 1 && ph <= 5) ? (3'b001 << g_m) : 3'b000;
      ev = (ph == 2) && vld[g_m];
      chk("gnt", 64'(gnt_o), 64'(eg));
      chk("start", 64'(core_start_o), 64'(ph == 1));
      chk("process", 64'(core_process_o), 64'(ph == 3));
      chk("busy", 64'(busy_o), 64'(ph >= 1 && ph <= 5));
      chk("error", 64'(error_o), 64'(ph == 6));
      chk("ready", 64'(req_ready_o), 64'((ph == 2 && fifo_ready) ? eg : 3'b000));
      chk("fifo_valid", 64'(fifo_valid_o), 64'(ev));
      if (ev) begin
        chk("fifo_data", fifo_data_o, dat[g_m]);
        chk("fifo_strb", 64'(fifo_strb_o), 64'(stb[g_m]));
      end
      chk("req_done", 64'(req_done_o), 64'((ph == 5) ? eg : 3'b000));
      chk("core_done", 64'(core_done_o), 64'(ph == 5 && ack[g_m]));
      case (ph)
        0: begin
          nxt = rr(ptr_m, req);
          if (nxt >= 0) begin
            g_m = 2'(nxt); ptr_m = 2'(nxt); ph = 1;
          end
        end
        1: begin ph = 2; tcnt_m = 0; end
        2: begin
          if (vld[g_m] && fifo_ready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
              chk("beat_pending", 64'(exp_q.size()), 64'd1);
            end else begin
              b = exp_q.pop_front();
              chk("beat_data", fifo_data_o, b.d);
              chk("beat_strb", 64'(fifo_strb_o), 64'(b.s));
            end
            tcnt_m = 0;
            if (last[g_m]) ph = 3;
          end else begin
            tcnt_m++;
            if (tcnt_m == TO) ph = 6;
          end
        end
        3: ph = 4;
        4: if (absorbed) ph = 5;
        5: if (ack[g_m]) ph = 0;
        default: ;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  int seq = 0;

  task automatic do_reset();
    rst = 1'b1;
    req = '0; vld = '0; last = '0; ack = '0; absorbed = 1'b0; fifo_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 64'({gnt_o, req_ready_o, req_done_o, fifo_valid_o, core_start_o,
                           core_process_o, core_done_o, busy_o, error_o}), 64'd0);
    rst = 1'b0;
  endtask

  task automatic send_beats(input logic [1:0] g, input int n, input bit bp,
                            input bit with_last, input bit zero_last_strb);
    int cyc;
    bit got;
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = {8'(g), 8'(k), 16'hBEEF, 32'(seq)};
      b.s = (zero_last_strb && k == n - 1) ? 8'h00 : (8'hFF >> k);
      seq++;
      exp_q.push_back(b);
      dat[g] = b.d; stb[g] = b.s;
      vld[g] = 1'b1;
      last[g] = with_last && (k == n - 1);
      cyc = 0;
      got = 1'b0;
      while (!got) begin
        @(negedge clk);
        got = req_ready_o[g] && fifo_ready;
        @(posedge clk);
        #1;
        if (bp) fifo_ready = ~fifo_ready;
        cyc++;
        if (!got && cyc > 40) begin
          chk("beat_accept_timeout", 64'(cyc), 64'd40);
          got = 1'b1;
        end
      end
    end
    vld[g] = 1'b0;
    last[g] = 1'b0;
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    int n;
    n = 0;
    while (gnt_o == 3'b000 && n < 20) begin
      tick();
      n++;
    end
    chk("gnt_wait", 64'(gnt_o != 3'b000), 64'd1);
    g = gnt_o[2] ? 2'd2 : (gnt_o[1] ? 2'd1 : 2'd0);
  endtask

  task automatic run_op(input int n, input bit bp, output logic [1:0] g);
    wait_gnt(g);
    send_beats(g, n, bp, 1'b1, 1'b0);
    fifo_ready = 1'b1;
    chk("proc_latency", 64'(core_process_o), 64'd1);
    tick();
    absorbed = 1'b1;
    tick();
    absorbed = 1'b0;
    ack[g] = 1'b1;
    tick();
    ack[g] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] g;
    logic [1:0] rr_exp [4];
    int b0;
    for (int i = 0; i < 3; i++) begin dat[i] = '0; stb[i] = '0; end
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd0;
    #1;
    do_reset();

    // Single request from requester 1, three beats, zero-strobe last beat.
    tick();
    req = 3'b010;
    tick();
    chk("t1_gnt", 64'(gnt_o), 64'(3'b010));
    chk("t1_start", 64'(core_start_o), 64'd1);
    req = 3'b000;
    b0 = beats_seen;
    send_beats(2'd1, 3, 1'b0, 1'b1, 1'b1);
    chk("t1_beats", 64'(beats_seen - b0), 64'd3);
    chk("t1_process", 64'(core_process_o), 64'd1);
    tick();
    chk("t1_process_off", 64'(core_process_o), 64'd0);
    chk("t1_done_early", 64'(req_done_o), 64'd0);
    absorbed = 1'b1;
    tick();
    absorbed = 1'b0;
    chk("t1_req_done", 64'(req_done_o), 64'(3'b010));
    ack = 3'b010;
    #1;
    chk("t1_core_done", 64'(core_done_o), 64'd1);
    tick();
    ack = 3'b000;
    chk("t1_gnt_clr", 64'(gnt_o), 64'd0);
    chk("t1_core_done_off", 64'(core_done_o), 64'd0);

    // Round robin with all requesters held.
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      run_op(2, 1'b0, g);
      chk("rr_order", 64'(g), 64'(rr_exp[i]));
    end
    req = 3'b000;
    tick();

    // Backpressure: fifo_ready toggles every cycle.
    req = 3'b001;
    b0 = beats_seen;
    run_op(5, 1'b1, g);
    req = 3'b000;
    chk("bp_gnt", 64'(g), 64'd0);
    chk("bp_beats", 64'(beats_seen - b0), 64'd5);
    tick();

    // Stray core_absorbed in StMsg and stray ack from requester 0.
    req = 3'b100;
    wait_gnt(g);
    chk("stray_gnt", 64'(gnt_o), 64'(3'b100));
    req = 3'b000;
    tick();
    absorbed = 1'b1;
    tick();
    absorbed = 1'b0;
    chk("stray_abs_gnt", 64'(gnt_o), 64'(3'b100));
    chk("stray_abs_done", 64'(req_done_o), 64'd0);
    send_beats(2'd2, 1, 1'b0, 1'b1, 1'b1);
    chk("stray_process", 64'(core_process_o), 64'd1);
    tick();
    absorbed = 1'b1;
    tick();
    absorbed = 1'b0;
    ack = 3'b001;
    #1;
    chk("stray_ack_core_done", 64'(core_done_o), 64'd0);
    tick();
    ack = 3'b000;
    chk("stray_ack_hold", 64'(req_done_o), 64'(3'b100));
    ack = 3'b100;
    #1;
    chk("stray_real_ack", 64'(core_done_o), 64'd1);
    tick();
    ack = 3'b000;
    chk("stray_gnt_clr", 64'(gnt_o), 64'd0);
    chk("q_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of StMsg.
    req = 3'b010;
    wait_gnt(g);
    req = 3'b000;
    tick();
    fifo_ready = 1'b0;
    dat[1] = 64'h1234_5678_9ABC_DEF0; stb[1] = 8'hF0;
    vld[1] = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 64'({gnt_o, req_ready_o, req_done_o, fifo_valid_o, core_start_o,
                             core_process_o, core_done_o, busy_o, error_o}), 64'd0);
    chk("mid_rst_data", fifo_data_o, 64'd0);
    vld = 3'b000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fifo_ready = 1'b1;
    req = 3'b100;
    tick();
    chk("post_rst_gnt", 64'(gnt_o), 64'(3'b100));
    chk("post_rst_start", 64'(core_start_o), 64'd1);
    req = 3'b000;
    run_op(1, 1'b0, g);
    tick();

    // Stream timeout: one beat, then silence.
    req = 3'b001;
    wait_gnt(g);
    req = 3'b000;
    send_beats(2'd0, 1, 1'b0, 1'b0, 1'b0);
    repeat (TO - 1) tick();
    chk("to_not_yet", 64'(error_o), 64'd0);
    tick();
    chk("to_error", 64'(error_o), 64'd1);
    chk("to_gnt", 64'(gnt_o), 64'd0);
    chk("to_busy", 64'(busy_o), 64'd0);
    req = 3'b111;
    repeat (4) tick();
    chk("to_ignore_gnt", 64'(gnt_o), 64'd0);
    chk("to_sticky", 64'(error_o), 64'd1);
    req = 3'b000;

    do_reset();
    chk("final_error_clr", 64'(error_o), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
